// File: rtl/ring_heater_lock_ctrl.sv
// ring_heater_lock_ctrl: dither-based thermal lock loop for one ring heater.
// Averages 2^AVG_LOG2 thru-port monitor samples per heater code and steps the code
// toward lower thru power, reversing direction whenever a step does not improve.
// The heater is driven both as a plain code and as a first-order PDM bit stream.
// Optional feature macro: RING_LOCK_WATCHDOG_EN (sample-starvation watchdog, sticky fault).
module ring_heater_lock_ctrl #(
    parameter int unsigned CODE_W        = 8,
    parameter int unsigned SAMPLE_W      = 10,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned STEP          = 1,
    parameter int unsigned HEATER_INIT   = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                pd_valid,
    output logic                pd_ready,
    input  logic [SAMPLE_W-1:0] pd_sample,
    output logic [CODE_W-1:0]   heater_code,
    output logic                heater_pdm,
    output logic                locked,
    output logic                fault
);

    localparam int unsigned SUM_W     = SAMPLE_W + AVG_LOG2;
    localparam int unsigned CNT_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned CNT_LAST  = (1 << AVG_LOG2) - 1;
    localparam int unsigned SET_W     = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned REV_W     = 3;
    localparam int unsigned REV_MAX   = 7;
    localparam int unsigned LOCK_REVS = 4;
`ifdef RING_LOCK_WATCHDOG_EN
    localparam int unsigned WD_W      = 8;
    localparam int unsigned WD_LIMIT  = 255;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_STEP
    } state_t;

    state_t             state, state_nxt;
    logic [SET_W-1:0]   settle_cnt, settle_nxt;
    logic [CNT_W-1:0]   xfer_cnt, xfer_nxt;
    logic [SUM_W-1:0]   sum, sum_nxt;
    logic [SUM_W-1:0]   prev, prev_nxt;
    logic               first_meas, first_nxt;
    logic               dir_up, dir_nxt;
    logic [REV_W-1:0]   rev_cnt, rev_nxt;
    logic [CODE_W-1:0]  code_nxt;
    logic [CODE_W:0]    code_inc;
    logic [CODE_W-1:0]  pdm_acc;
    logic               ready_nxt;
    logic               locked_nxt;
    logic               xfer;
    logic               abort;
    logic               start_ok;
`ifdef RING_LOCK_WATCHDOG_EN
    logic [WD_W-1:0]    wd_cnt, wd_nxt;
    logic               fault_nxt;
    logic               en_q;
`endif

    assign xfer = pd_valid & pd_ready;

`ifndef RING_LOCK_WATCHDOG_EN
    assign fault = 1'b0;
`endif

    // Next-state and datapath decisions for the dither loop
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        xfer_nxt   = xfer_cnt;
        sum_nxt    = sum;
        prev_nxt   = prev;
        first_nxt  = first_meas;
        dir_nxt    = dir_up;
        rev_nxt    = rev_cnt;
        code_nxt   = heater_code;
        code_inc   = {1'b0, heater_code} + (CODE_W + 1)'(STEP);
        abort      = 1'b0;
        start_ok   = enable;
`ifdef RING_LOCK_WATCHDOG_EN
        wd_nxt     = wd_cnt;
        fault_nxt  = fault;
        // A fresh enable edge re-arms the loop after a fault
        if (enable && !en_q) begin
            fault_nxt = 1'b0;
        end
        start_ok   = enable && !fault_nxt;
`endif

        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    settle_nxt = SET_W'(SETTLE_CYCLES);
                    state_nxt  = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (settle_cnt <= SET_W'(1)) begin
                    state_nxt = S_MEASURE;
                end else begin
                    settle_nxt = settle_cnt - SET_W'(1);
                end
            end

            S_MEASURE: begin
                if (xfer) begin
                    sum_nxt = sum + SUM_W'(pd_sample);
                    if (xfer_cnt == CNT_W'(CNT_LAST)) begin
                        xfer_nxt  = '0;
                        state_nxt = S_COMPARE;
                    end else begin
                        xfer_nxt = xfer_cnt + CNT_W'(1);
                    end
                end
`ifdef RING_LOCK_WATCHDOG_EN
                if (xfer) begin
                    wd_nxt = '0;
                end else if (wd_cnt == WD_W'(WD_LIMIT - 1)) begin
                    fault_nxt = 1'b1;
                    abort     = 1'b1;
                end else begin
                    wd_nxt = wd_cnt + WD_W'(1);
                end
`endif
            end

            S_COMPARE: begin
                // Ties count as worse so a flat response keeps reversing
                if (first_meas) begin
                    first_nxt = 1'b0;
                end else if (sum < prev) begin
                    rev_nxt = '0;
                end else begin
                    dir_nxt = ~dir_up;
                    rev_nxt = (rev_cnt == REV_W'(REV_MAX)) ? rev_cnt : rev_cnt + REV_W'(1);
                end
                prev_nxt  = sum;
                sum_nxt   = '0;
                state_nxt = S_STEP;
            end

            S_STEP: begin
                // Clipping at either rail turns the dither around
                if (dir_up) begin
                    if (code_inc[CODE_W]) begin
                        code_nxt = '1;
                        dir_nxt  = 1'b0;
                    end else begin
                        code_nxt = code_inc[CODE_W-1:0];
                    end
                end else begin
                    if (heater_code < CODE_W'(STEP)) begin
                        code_nxt = '0;
                        dir_nxt  = 1'b1;
                    end else begin
                        code_nxt = heater_code - CODE_W'(STEP);
                    end
                end
                settle_nxt = SET_W'(SETTLE_CYCLES);
                state_nxt  = S_SETTLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Disable (or watchdog trip) abandons the measurement; code and direction hold
        if (!enable || abort) begin
            state_nxt = S_IDLE;
            sum_nxt   = '0;
            xfer_nxt  = '0;
            first_nxt = 1'b1;
            rev_nxt   = '0;
            code_nxt  = heater_code;
            dir_nxt   = dir_up;
`ifdef RING_LOCK_WATCHDOG_EN
            wd_nxt    = '0;
`endif
        end

        ready_nxt  = (state_nxt == S_MEASURE);
        locked_nxt = (rev_nxt >= REV_W'(LOCK_REVS));
    end

    // Loop state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            xfer_cnt    <= '0;
            sum         <= '0;
            prev        <= '0;
            first_meas  <= 1'b1;
            dir_up      <= 1'b1;
            rev_cnt     <= '0;
            heater_code <= CODE_W'(HEATER_INIT);
            pd_ready    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_nxt;
            settle_cnt  <= settle_nxt;
            xfer_cnt    <= xfer_nxt;
            sum         <= sum_nxt;
            prev        <= prev_nxt;
            first_meas  <= first_nxt;
            dir_up      <= dir_nxt;
            rev_cnt     <= rev_nxt;
            heater_code <= code_nxt;
            pd_ready    <= ready_nxt;
            locked      <= locked_nxt;
        end
    end

    // First-order PDM: the accumulator carry is the heater bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdm_acc    <= '0;
            heater_pdm <= 1'b0;
        end else begin
            {heater_pdm, pdm_acc} <= {1'b0, pdm_acc} + {1'b0, heater_code};
        end
    end

`ifdef RING_LOCK_WATCHDOG_EN
    // Starvation watchdog and sticky fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            fault  <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            wd_cnt <= wd_nxt;
            fault  <= fault_nxt;
            en_q   <= enable;
        end
    end
`endif

endmodule

// File: tb/tb_ring_heater_lock_ctrl.sv
// Scoreboard bench for ring_heater_lock_ctrl: the driver feeds samples from a
// synthetic ring response and predicts each new heater code / lock flag from the
// dither rules; the monitor checks them at the start of every measurement window.
module tb_ring_heater_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       pd_valid;
    logic       pd_ready;
    logic [9:0] pd_sample;
    logic [7:0] heater_code;
    logic       heater_pdm;
    logic       locked;
    logic       fault;

    always #5 clk = ~clk;

    ring_heater_lock_ctrl #(
        .CODE_W(8), .SAMPLE_W(10), .AVG_LOG2(2),
        .SETTLE_CYCLES(16), .STEP(1), .HEATER_INIT(128)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pd_valid(pd_valid), .pd_ready(pd_ready), .pd_sample(pd_sample),
        .heater_code(heater_code), .heater_pdm(heater_pdm),
        .locked(locked), .fault(fault)
    );

    typedef struct {
        int code;
        int lck;
        int gap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference loop state
    int m_code  = 128;
    int m_dir   = 1;
    int m_rev   = 0;
    int m_first = 1;
    int m_prev  = 0;
    int m_sum   = 0;
    int m_cnt   = 0;

    int mode        = 0;
    bit force_valid = 0;
    bit valid_off   = 0;
    bit rand_drop   = 0;
    int hold_off    = 0;
    bit wd_test     = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Synthetic thru-port power versus heater code
    function automatic int power(input int md, input int c);
        int d;
        d = (c > 140) ? c - 140 : 140 - c;
        case (md)
            0:       return 1000 - c;
            1:       return 4 * d + 100;
            2:       return 500;
            3:       return 200 + 2 * c;
            default: return 4 * d + 100 + int'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic push_exp(input int code, input int lck, input int gap);
        exp_t e;
        e.code = code;
        e.lck  = lck;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    // One accepted sample; every fourth closes a measurement and predicts the step
    task automatic model_accept(input int s);
        int nc;
        m_sum += s;
        m_cnt++;
        if (m_cnt == 4) begin
            if (m_first != 0) begin
                m_first = 0;
            end else if (m_sum < m_prev) begin
                m_rev = 0;
            end else begin
                m_dir = -m_dir;
                if (m_rev < 7) m_rev++;
            end
            m_prev = m_sum;
            m_sum  = 0;
            m_cnt  = 0;
            nc = m_code + m_dir;
            if (nc > 255) begin
                nc = 255;
                m_dir = -m_dir;
            end else if (nc < 0) begin
                nc = 0;
                m_dir = -m_dir;
            end
            m_code = nc;
            push_exp(m_code, (m_rev >= 4) ? 1 : 0, 18);
        end
    endtask

    task automatic model_abort();
        m_sum   = 0;
        m_cnt   = 0;
        m_first = 1;
        m_rev   = 0;
    endtask

    // Drive one cycle of stimulus at the falling edge
    task automatic tick(input bit en);
        bit en_eff;
        @(negedge clk);
        en_eff = en;
        if (rand_drop && enable && pd_ready && hold_off == 0 && $urandom_range(0, 199) == 0)
            hold_off = $urandom_range(1, 5);
        if (hold_off > 0) begin
            en_eff = 1'b0;
            hold_off--;
        end
        if (enable && !en_eff) model_abort();
        if (!enable && en_eff) push_exp(m_code, 0, -1);
        enable = en_eff;
        if (force_valid) pd_valid = 1'b1;
        else if (valid_off) pd_valid = 1'b0;
        else pd_valid = ($urandom_range(0, 3) != 0);
        if (pd_valid) pd_sample = 10'(power(mode, m_code));
        else pd_sample = 10'($urandom_range(0, 1023));
        if (enable && pd_valid && pd_ready) model_accept(int'(pd_sample));
    endtask

    // Drop enable after two transfers of a window and check the abort
    task automatic drop_after_two();
        bit found = 0;
        force_valid = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1'b1);
            if (m_cnt == 2) found = 1;
        end
        check("drop_window_reached", int'(found), 1);
        tick(1'b0);
        force_valid = 1'b0;
        tick(1'b0);
        check("drop_ready_low", int'(pd_ready), 0);
        check("drop_locked_low", int'(locked), 0);
        check("drop_code_held", int'(heater_code), m_code);
        repeat (2) tick(1'b0);
    endtask

    // Monitor: compare each window against the scoreboard
    initial begin
        bit prev_rd = 0;
        bit prev_en = 0;
        int xfers = 0;
        int gap = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (pd_ready && !prev_rd) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL window_expected: got window start, expected none (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        check("window_code", int'(heater_code), e.code);
                        check("window_locked", int'(locked), e.lck);
                        if (e.gap >= 0) check("ready_gap", gap, e.gap);
                    end
                    xfers = 0;
                end
                if (pd_ready && enable && pd_valid) xfers++;
                if (!pd_ready && prev_rd) begin
                    if (prev_en && !wd_test) check("window_transfers", xfers, 4);
                    gap = 0;
                end
                if (!pd_ready) gap++;
                prev_rd = pd_ready;
                prev_en = enable;
            end
        end
    end

    // Stimulus sequence
    initial begin
        int ones = 0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        pd_valid  = 1'b0;
        pd_sample = '0;
        repeat (3) @(negedge clk);
        check("rst_code", int'(heater_code), 128);
        check("rst_ready", int'(pd_ready), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_pdm", int'(heater_pdm), 0);
        rst_n = 1'b1;

        // Idle: code held, PDM at 50 % density
        for (int i = 0; i < 512; i++) begin
            tick(1'b0);
            if (heater_pdm) ones++;
        end
        check_range("pdm_ones_512", ones, 255, 257);
        check("idle_code", int'(heater_code), 128);
        check("idle_ready", int'(pd_ready), 0);

        // Power falls as code rises: climbs to the top rail and sticks
        mode = 0;
        repeat (4000) tick(1'b1);
        check("sat_high_code", int'(heater_code), 255);

        drop_after_two();
        mode = 1;
        repeat (4000) tick(1'b1);
        check_range("v_dither_code", int'(heater_code), 139, 141);

        drop_after_two();
        mode = 2;
        repeat (600) tick(1'b1);
        check("flat_locked", int'(locked), 1);

        drop_after_two();
        mode = 3;
        repeat (5000) tick(1'b1);
        check("sat_low_code", int'(heater_code), 0);

        drop_after_two();
        mode = 4;
        rand_drop = 1'b1;
        repeat (3000) tick(1'b1);
        rand_drop = 1'b0;

        drop_after_two();
        repeat (30) tick(1'b0);
        check("scoreboard_drained", sb.size(), 0);
        check("fault_clear", int'(fault), 0);

`ifdef RING_LOCK_WATCHDOG_EN
        begin
            bit seen = 0;
            int n = 0;
            wd_test   = 1'b1;
            valid_off = 1'b1;
            for (int i = 0; i < 60 && !seen; i++) begin
                tick(1'b1);
                if (pd_ready) seen = 1;
            end
            check("wd_measure_reached", int'(seen), 1);
            seen = 0;
            for (int i = 0; i < 300 && !seen; i++) begin
                tick(1'b1);
                n++;
                if (fault) seen = 1;
            end
            check("wd_fault_set", int'(fault), 1);
            check_range("wd_fault_cycles", n, 254, 256);
            check("wd_ready_low", int'(pd_ready), 0);
            tick(1'b0);
            tick(1'b1);
            tick(1'b1);
            check("wd_fault_cleared", int'(fault), 0);
            tick(1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
